// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   Serial transmit engine of the UART peripheral. Takes a byte from the
//   send-data CSR and shifts it out as: start bit, data LSB-first, optional
//   parity bit, then one or two stop bits. Bit timing comes from a down-counter
//   reloaded from the baud divisor at every bit start. Divisor and format
//   fields are captured when a byte is accepted, so CSR writes made while a
//   frame is in flight only affect the next frame.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   baud_div    clocks per bit minus 1
//   tx_en       transmitter enable
//   parity_en   append a parity bit
//   parity_odd  1 = odd parity, 0 = even parity
//   two_stop    1 = two stop bits
//   send_valid  send-data CSR holds a byte
//   send_data   byte to transmit
//   send_ready  engine accepts a byte this cycle (combinational)
//   tx          serial line, idle high (registered)
//   tx_busy     frame in progress
//   tx_done     one-cycle pulse when a frame completes
//
// state  | meaning
// -------+---------------------------------------------
// IDLE   | line high, waiting for send_valid & send_ready
// START  | driving the start bit (low)
// DATA   | shifting out payload bits, LSB first
// PARITY | driving the parity bit
// STOP   | driving one or two stop bits (high)

module uart_tx_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  tx_en,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  two_stop,
    input  logic                  send_valid,
    input  logic [DATA_WIDTH-1:0] send_data,
    output logic                  send_ready,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_next;
    logic                  tx_q, tx_next;
    logic                  busy_q, busy_next;
    logic                  done_q, done_next;
    logic [DATA_WIDTH-1:0] shift_q, shift_next;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_next;
    logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_next;
    logic [DIV_WIDTH-1:0]  div_q, div_next;
    logic                  stop_cnt_q, stop_cnt_next;
    logic                  pen_q, pen_next;
    logic                  two_stop_q, two_stop_next;
    logic                  par_q, par_next;
    logic                  bit_end;
    logic                  accept;

    assign send_ready = tx_en & (state_q == IDLE);
    assign accept     = send_valid & send_ready;
    assign bit_end    = (baud_cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            div_q      <= '0;
            stop_cnt_q <= 1'b0;
            pen_q      <= 1'b0;
            two_stop_q <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            state_q    <= state_next;
            tx_q       <= tx_next;
            busy_q     <= busy_next;
            done_q     <= done_next;
            shift_q    <= shift_next;
            bit_cnt_q  <= bit_cnt_next;
            baud_cnt_q <= baud_cnt_next;
            div_q      <= div_next;
            stop_cnt_q <= stop_cnt_next;
            pen_q      <= pen_next;
            two_stop_q <= two_stop_next;
            par_q      <= par_next;
        end
    end

    always_comb begin
        state_next    = state_q;
        tx_next       = tx_q;
        busy_next     = busy_q;
        done_next     = 1'b0;
        shift_next    = shift_q;
        bit_cnt_next  = bit_cnt_q;
        baud_cnt_next = baud_cnt_q;
        div_next      = div_q;
        stop_cnt_next = stop_cnt_q;
        pen_next      = pen_q;
        two_stop_next = two_stop_q;
        par_next      = par_q;

        // Bit timer: reload from the captured divisor at each bit boundary.
        if (state_q != IDLE) begin
            baud_cnt_next = bit_end ? div_q : (baud_cnt_q - DIV_WIDTH'(1));
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_next    = START;
                    tx_next       = 1'b0;
                    busy_next     = 1'b1;
                    shift_next    = send_data;
                    bit_cnt_next  = '0;
                    stop_cnt_next = 1'b0;
                    baud_cnt_next = baud_div;
                    div_next      = baud_div;
                    pen_next      = parity_en;
                    two_stop_next = two_stop;
                    par_next      = parity_odd ? ~(^send_data) : (^send_data);
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    tx_next      = shift_q[0];
                    shift_next   = shift_q >> 1;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (pen_q) begin
                            state_next = PARITY;
                            tx_next    = par_q;
                        end else begin
                            state_next    = STOP;
                            tx_next       = 1'b1;
                            stop_cnt_next = 1'b0;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_q + BIT_W'(1);
                        tx_next      = shift_q[0];
                        shift_next   = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next    = STOP;
                    tx_next       = 1'b1;
                    stop_cnt_next = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // stop_cnt marks that the first of two stop bits is done.
                    if (two_stop_q && !stop_cnt_q) begin
                        stop_cnt_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

    logic        clk;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        tx_en;
    logic        parity_en;
    logic        parity_odd;
    logic        two_stop;
    logic        send_valid;
    logic [7:0]  send_data;
    logic        send_ready;
    logic        tx;
    logic        tx_busy;
    logic        tx_done;

    int checks;
    int failures;

    uart_tx_engine #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_div   (baud_div),
        .tx_en      (tx_en),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .send_valid (send_valid),
        .send_data  (send_data),
        .send_ready (send_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks one frame starting at the first start-bit cycle; returns at the
    // cycle after the last stop bit (where tx_done is expected).
    task automatic walk_frame(input logic [7:0] data, input int div, input bit pen,
                              input bit par, input bit ts,
                              output int tx_err, output int st_err);
        logic [11:0] eb;
        int n;
        eb = '0;
        eb[0] = 1'b0;
        for (int i = 0; i < 8; i++) eb[1+i] = data[i];
        n = 9;
        if (pen) begin eb[n] = par; n++; end
        eb[n] = 1'b1; n++;
        if (ts) begin eb[n] = 1'b1; n++; end
        tx_err = 0;
        st_err = 0;
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k <= div; k++) begin
                if (tx !== eb[b]) tx_err++;
                if (tx_busy !== 1'b1 || tx_done !== 1'b0) st_err++;
                step();
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tx_en = 1'b0; send_valid = 1'b0; send_data = 8'h00;
        baud_div = 16'd0; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        #12;
        checks++;
        if ({tx, tx_busy, tx_done, send_ready} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_state: got tx/busy/done/ready=%b required 1000",
                     {tx, tx_busy, tx_done, send_ready});
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_8n1();
        int te, se;
        tx_en = 1'b1; baud_div = 16'd3; parity_en = 1'b0; two_stop = 1'b0;
        send_data = 8'hA5; send_valid = 1'b1;
        #1;
        checks++;
        if (send_ready !== 1'b1) begin
            failures++; $display("FAIL 8n1_ready: got %b required 1", send_ready);
        end
        step();
        // CSR changes after accept must not disturb the frame in flight
        send_valid = 1'b0; baud_div = 16'd0; two_stop = 1'b1; parity_en = 1'b1;
        walk_frame(8'hA5, 3, 1'b0, 1'b0, 1'b0, te, se);
        checks++;
        if (te !== 0) begin failures++; $display("FAIL 8n1_tx_bits: got %0d bad cycles required 0", te); end
        checks++;
        if (se !== 0) begin failures++; $display("FAIL 8n1_busy: got %0d bad cycles required 0", se); end
        checks++;
        if ({tx_done, tx_busy, tx} !== 3'b101) begin
            failures++; $display("FAIL 8n1_done_at_40: got done/busy/tx=%b required 101", {tx_done, tx_busy, tx});
        end
        step();
        checks++;
        if ({tx_done, tx_busy, tx} !== 3'b001) begin
            failures++; $display("FAIL 8n1_done_clear: got done/busy/tx=%b required 001", {tx_done, tx_busy, tx});
        end
    endtask

    task automatic test_parity();
        int te, se;
        logic [1:0] podd_v = 2'b10;
        logic [1:0] pexp_v = 2'b10;  // A5 has four ones: even->0, odd->1
        for (int r = 0; r < 2; r++) begin
            baud_div = 16'd1; parity_en = 1'b1; two_stop = 1'b0;
            parity_odd = podd_v[r]; send_data = 8'hA5; send_valid = 1'b1;
            step();
            send_valid = 1'b0;
            walk_frame(8'hA5, 1, 1'b1, pexp_v[r], 1'b0, te, se);
            checks++;
            if (te !== 0 || se !== 0) begin
                failures++; $display("FAIL parity_frame odd=%0b: got %0d/%0d bad cycles required 0/0", podd_v[r], te, se);
            end
            checks++;
            if ({tx_done, tx_busy} !== 2'b10) begin
                failures++; $display("FAIL parity_done_at_22 odd=%0b: got done/busy=%b required 10", podd_v[r], {tx_done, tx_busy});
            end
            step();
        end
        parity_en = 1'b0; parity_odd = 1'b0;
    endtask

    task automatic test_two_stop();
        int te, se;
        baud_div = 16'd0; two_stop = 1'b1; send_data = 8'hFF; send_valid = 1'b1;
        step();
        send_valid = 1'b0;
        walk_frame(8'hFF, 0, 1'b0, 1'b0, 1'b1, te, se);
        checks++;
        if (te !== 0 || se !== 0) begin
            failures++; $display("FAIL two_stop_frame: got %0d/%0d bad cycles required 0/0", te, se);
        end
        checks++;
        if ({tx_done, tx_busy} !== 2'b10) begin
            failures++; $display("FAIL two_stop_done_at_11: got done/busy=%b required 10", {tx_done, tx_busy});
        end
        step();
        two_stop = 1'b0;
    endtask

    task automatic test_back_to_back();
        int te, se;
        baud_div = 16'd0; send_data = 8'h01; send_valid = 1'b1;
        step();
        send_data = 8'h80;
        walk_frame(8'h01, 0, 1'b0, 1'b0, 1'b0, te, se);
        checks++;
        if (te !== 0 || se !== 0) begin
            failures++; $display("FAIL b2b_frame1: got %0d/%0d bad cycles required 0/0", te, se);
        end
        checks++;
        if ({tx_done, send_ready, tx} !== 3'b111) begin
            failures++; $display("FAIL b2b_done_ready: got done/ready/tx=%b required 111", {tx_done, send_ready, tx});
        end
        step();
        send_valid = 1'b0;
        walk_frame(8'h80, 0, 1'b0, 1'b0, 1'b0, te, se);
        checks++;
        if (te !== 0 || se !== 0) begin
            failures++; $display("FAIL b2b_frame2: got %0d/%0d bad cycles required 0/0", te, se);
        end
        checks++;
        if ({tx_done, tx_busy} !== 2'b10) begin
            failures++; $display("FAIL b2b_frame2_done: got done/busy=%b required 10", {tx_done, tx_busy});
        end
        step();
    endtask

    task automatic test_reset_mid_frame();
        int te, se;
        baud_div = 16'd3; send_data = 8'h00; send_valid = 1'b1;
        step();
        send_valid = 1'b0;
        repeat (21) step();   // middle of data bit 4
        checks++;
        if ({tx, tx_busy} !== 2'b01) begin
            failures++; $display("FAIL midframe_pre_reset: got tx/busy=%b required 01", {tx, tx_busy});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx, tx_busy, tx_done} !== 3'b100) begin
            failures++; $display("FAIL midframe_reset_async: got tx/busy/done=%b required 100", {tx, tx_busy, tx_done});
        end
        step();
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (send_ready !== 1'b1) begin
            failures++; $display("FAIL post_reset_ready: got %b required 1", send_ready);
        end
        step();
        baud_div = 16'd1; send_data = 8'h3C; send_valid = 1'b1;
        step();
        send_valid = 1'b0;
        walk_frame(8'h3C, 1, 1'b0, 1'b0, 1'b0, te, se);
        checks++;
        if (te !== 0 || se !== 0 || tx_done !== 1'b1) begin
            failures++; $display("FAIL post_reset_frame: got %0d/%0d bad cycles done=%b required 0/0 done=1", te, se, tx_done);
        end
        step();
    endtask

    task automatic test_tx_en();
        int bad, te, se;
        tx_en = 1'b0; send_valid = 1'b1; send_data = 8'h5A; baud_div = 16'd0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (send_ready !== 1'b0 || tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++; $display("FAIL disabled_ignored: got %0d bad cycles required 0", bad);
        end
        baud_div = 16'd2; send_data = 8'h55; tx_en = 1'b1;
        step();
        tx_en = 1'b0;   // cleared mid-frame, send_valid still high
        walk_frame(8'h55, 2, 1'b0, 1'b0, 1'b0, te, se);
        checks++;
        if (te !== 0 || se !== 0 || tx_done !== 1'b1) begin
            failures++; $display("FAIL disable_midframe: got %0d/%0d bad cycles done=%b required 0/0 done=1", te, se, tx_done);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (send_ready !== 1'b0 || tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++; $display("FAIL disable_no_accept: got %0d bad cycles required 0", bad);
        end
        send_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_8n1();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_mid_frame();
        test_tx_en();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
